// File: rtl/qfind_pkg.sv
// Shared types for the queue find engine: compare modes, FSM states
// and the count-width helper.
package qfind_pkg;

    typedef enum logic [2:0] {
        MODE_EQ = 3'd0,
        MODE_NE = 3'd1,
        MODE_LT = 3'd2,
        MODE_GT = 3'd3,
        MODE_LE = 3'd4,
        MODE_GE = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/qfind_cmp.sv
// One search lane: unsigned predicate entry <op> key, gated by valid.
// Mode codes 6 and 7 never match.
module qfind_cmp
    import qfind_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] entry,
    input  logic [WIDTH-1:0] key,
    input  logic [2:0]       mode,
    input  logic             valid,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_EQ: hit = (entry == key);
            MODE_NE: hit = (entry != key);
            MODE_LT: hit = (entry <  key);
            MODE_GT: hit = (entry >  key);
            MODE_LE: hit = (entry <= key);
            MODE_GE: hit = (entry >= key);
            default: hit = 1'b0;
        endcase
        if (!valid) hit = 1'b0;
    end

endmodule

// File: rtl/queue_find_engine.sv
// Circular FIFO with a LANES-wide scanning find engine.
// Define QFIND_FIRST_LAST_EN to build first_idx/last_idx/any_found.
module queue_find_engine
    import qfind_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ready,
    input  logic                       pop_en,
    output logic [WIDTH-1:0]           pop_data,
    output logic [cnt_w(DEPTH)-1:0]    size,
    output logic                       full,
    output logic                       empty,
    input  logic                       find_start,
    input  logic [2:0]                 find_mode,
    input  logic [WIDTH-1:0]           find_key,
`ifdef QFIND_FIRST_LAST_EN
    output logic [$clog2(DEPTH)-1:0]   first_idx,
    output logic [$clog2(DEPTH)-1:0]   last_idx,
    output logic                       any_found,
`endif
    output logic                       find_busy,
    output logic                       find_done,
    output logic [cnt_w(DEPTH)-1:0]    find_count
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    size_q, size_d;
    logic             push_ok, pop_ok;

    state_e           state_q;
    logic [CW-1:0]    n_q, pos_q, count_q, hits_cnt;
    logic [AW-1:0]    base_q;
    logic [WIDTH-1:0] key_q;
    logic [2:0]       mode_q;
    logic             busy_q, done_q;
    logic [LANES-1:0] hit;

    assign full       = (size_q == CW'(DEPTH));
    assign empty      = (size_q == '0);
    assign size       = size_q;
    assign push_ready = !full && !busy_q;
    assign pop_data   = empty ? '0 : mem[rd_q];
    assign find_busy  = busy_q;
    assign find_done  = done_q;
    assign find_count = count_q;

    // On empty, pop_ok is false, so push+pop degenerates to push only.
    assign push_ok = push_valid && !full && !busy_q;
    assign pop_ok  = pop_en && !empty && !busy_q;
    assign rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
    assign wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    assign size_d  = size_q + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            size_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            size_q <= size_d;
        end
    end

`ifdef QFIND_FIRST_LAST_EN
    logic [AW-1:0] lane_pos [LANES];
    logic [AW-1:0] first_q, first_d, last_q, last_d;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [CW-1:0] p;
        logic [AW-1:0] a;
        assign p = pos_q + CW'(g);
        // Addressed from the snapshot base so positions stay queue-relative.
        assign a = base_q + p[AW-1:0];
`ifdef QFIND_FIRST_LAST_EN
        assign lane_pos[g] = p[AW-1:0];
`endif
        qfind_cmp #(.WIDTH(WIDTH)) u_cmp (
            .entry (mem[a]),
            .key   (key_q),
            .mode  (mode_q),
            .valid ((state_q == SCAN) && (p < n_q)),
            .hit   (hit[g])
        );
    end

    always_comb begin
        hits_cnt = '0;
        for (int l = 0; l < LANES; l++) hits_cnt = hits_cnt + CW'(hit[l]);
    end

`ifdef QFIND_FIRST_LAST_EN
    logic seen;
    always_comb begin
        first_d = first_q;
        last_d  = last_q;
        seen    = (count_q != '0);
        for (int l = 0; l < LANES; l++) begin
            if (hit[l]) begin
                if (!seen) first_d = lane_pos[l];
                seen   = 1'b1;
                last_d = lane_pos[l];
            end
        end
    end

    assign first_idx = first_q;
    assign last_idx  = last_q;
    assign any_found = (count_q != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            pos_q   <= '0;
            count_q <= '0;
            base_q  <= '0;
            key_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef QFIND_FIRST_LAST_EN
            first_q <= '0;
            last_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (find_start) begin
                        n_q     <= size_q;
                        key_q   <= find_key;
                        mode_q  <= find_mode;
                        base_q  <= rd_q;
                        count_q <= '0;
                        pos_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef QFIND_FIRST_LAST_EN
                        first_q <= '0;
                        last_q  <= '0;
`endif
                        if (size_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    count_q <= count_q + hits_cnt;
                    pos_q   <= pos_q + CW'(LANES);
`ifdef QFIND_FIRST_LAST_EN
                    first_q <= first_d;
                    last_q  <= last_d;
`endif
                    if ((CW+1)'(pos_q) + (CW+1)'(LANES) >= (CW+1)'(n_q)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_find_engine.sv
// Directed bench for queue_find_engine: queue ops, table of find
// vectors on a full 0..15 queue, wrap, frozen-while-busy and reset abort.
module tb_queue_find_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        pop_en;
    logic [31:0] pop_data;
    logic [4:0]  size;
    logic        full, empty;
    logic        find_start;
    logic [2:0]  find_mode;
    logic [31:0] find_key;
    logic        find_busy, find_done;
    logic [4:0]  find_count;
`ifdef QFIND_FIRST_LAST_EN
    logic [3:0]  first_idx, last_idx;
    logic        any_found;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    queue_find_engine #(.WIDTH(32), .DEPTH(16), .LANES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_en     (pop_en),
        .pop_data   (pop_data),
        .size       (size),
        .full       (full),
        .empty      (empty),
        .find_start (find_start),
        .find_mode  (find_mode),
        .find_key   (find_key),
`ifdef QFIND_FIRST_LAST_EN
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .any_found  (any_found),
`endif
        .find_busy  (find_busy),
        .find_done  (find_done),
        .find_count (find_count)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] key;
        int          cnt;
        int          first;
        int          last;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        push_valid = 1'b1;
        push_data  = v;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic pop();
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
    endtask

    task automatic run_find(input logic [2:0] m, input logic [31:0] k,
                            input bit noise, output int cyc);
        find_mode  = m;
        find_key   = k;
        find_start = 1'b1;
        tick();
        find_start = 1'b0;
        cyc = 1;
        if (noise) begin
            push_valid = 1'b1;
            push_data  = 32'd77;
            pop_en     = 1'b1;
            find_start = 1'b1;
            find_key   = 32'd18;
        end
        while (!find_done && cyc < 64) begin
            tick();
            cyc++;
        end
        push_valid = 1'b0;
        pop_en     = 1'b0;
        find_start = 1'b0;
        if (!find_done) begin
            checks++;
            failures++;
            $display("FAIL find_timeout actual=no_done required=done");
        end
    endtask

    initial begin
        int cyc;
        int seen_done;
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_en     = 1'b0;
        find_start = 1'b0;
        find_mode  = '0;
        find_key   = '0;

        tbl[0] = '{3'd2, 32'd5,   5,  0,  4, 9};
        tbl[1] = '{3'd0, 32'd7,   1,  7,  7, 9};
        tbl[2] = '{3'd1, 32'd7,  15,  0, 15, 9};
        tbl[3] = '{3'd3, 32'd12,  3, 13, 15, 9};
        tbl[4] = '{3'd4, 32'd3,   4,  0,  3, 9};
        tbl[5] = '{3'd5, 32'd15,  1, 15, 15, 9};
        tbl[6] = '{3'd6, 32'd0,   0,  0,  0, 9};
        tbl[7] = '{3'd3, 32'd100, 0,  0,  0, 9};

        repeat (2) tick();
        chk("rst_empty", int'(empty), 1);
        chk("rst_push_ready", int'(push_ready), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_size", int'(size), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        chk("rst_busy", int'(find_busy), 0);
        chk("rst_done", int'(find_done), 0);
        chk("rst_count", int'(find_count), 0);
        rst_n = 1'b1;
        tick();

        push(32'h0062617A);
        push(32'h00717578);
        chk("t1_size", int'(size), 2);
        chk("t1_front", int'(pop_data), 32'h0062617A);
        run_find(3'd0, 32'h0062617A, 1'b0, cyc);
        chk("t1_count", int'(find_count), 1);
        chk("t1_lat", cyc, 2);
`ifdef QFIND_FIRST_LAST_EN
        chk("t1_first", int'(first_idx), 0);
        chk("t1_last", int'(last_idx), 0);
`endif
        tick();
        chk("t1_idle", int'(find_busy), 0);

        pop();
        pop();
        chk("t3_empty", int'(empty), 1);
        run_find(3'd0, 32'd0, 1'b0, cyc);
        chk("t3_lat", cyc, 1);
        chk("t3_count", int'(find_count), 0);
`ifdef QFIND_FIRST_LAST_EN
        chk("t3_any", int'(any_found), 0);
`endif
        tick();

        for (int i = 0; i < 16; i++) push(32'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_ready", int'(push_ready), 0);
        push(32'd99);
        chk("t2_drop_size", int'(size), 16);

        for (int i = 0; i < 8; i++) begin
            run_find(tbl[i].mode, tbl[i].key, 1'b0, cyc);
            chk($sformatf("tbl%0d_count", i), int'(find_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_lat", i), cyc, tbl[i].lat);
`ifdef QFIND_FIRST_LAST_EN
            chk($sformatf("tbl%0d_first", i), int'(first_idx), tbl[i].first);
            chk($sformatf("tbl%0d_last", i), int'(last_idx), tbl[i].last);
            chk($sformatf("tbl%0d_any", i), int'(any_found),
                (tbl[i].cnt != 0) ? 1 : 0);
`endif
            tick();
        end

        pop();
        pop();
        pop();
        chk("t4_front", int'(pop_data), 3);
        push(32'd16);
        push(32'd17);
        push(32'd18);
        chk("t4_size", int'(size), 16);
        run_find(3'd5, 32'd16, 1'b0, cyc);
        chk("t4_count", int'(find_count), 3);
`ifdef QFIND_FIRST_LAST_EN
        chk("t4_first", int'(first_idx), 13);
        chk("t4_last", int'(last_idx), 15);
`endif
        tick();

        pop();
        chk("t5_size0", int'(size), 15);
        run_find(3'd0, 32'd4, 1'b1, cyc);
        chk("t5_count", int'(find_count), 1);
        chk("t5_lat", cyc, 9);
        chk("t5_size", int'(size), 15);
        chk("t5_front", int'(pop_data), 4);
`ifdef QFIND_FIRST_LAST_EN
        chk("t5_first", int'(first_idx), 0);
`endif
        tick();
        chk("t5_idle", int'(find_busy), 0);
        chk("t5_size_after", int'(size), 15);

        find_mode  = 3'd5;
        find_key   = 32'd0;
        find_start = 1'b1;
        tick();
        find_start = 1'b0;
        repeat (3) tick();
        chk("t6_busy_pre", int'(find_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_rst", int'(find_busy), 0);
        chk("t6_empty_rst", int'(empty), 1);
        repeat (2) tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (find_done) seen_done = 1;
        end
        chk("t6_no_done", seen_done, 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_ready", int'(push_ready), 1);
        chk("t6_size", int'(size), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
